// File: rtl/lmsm_sequencer.sv
// Expands one LM/SM into per-register micro-ops at consecutive word addresses, lowest register first.
// First micro-op one cycle after start; ds_ready low holds the current micro-op and keeps the front end stalled.
module lmsm_sequencer #(
    parameter int ADDR_W = 16,
    parameter int NREG   = 8,
    parameter int RIDX_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              is_sm,
    input  logic [NREG-1:0]   reg_list,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              flush,
    input  logic              ds_ready,
    output logic              uop_valid,
    output logic              uop_is_sm,
    output logic [RIDX_W-1:0] uop_reg,
    output logic [ADDR_W-1:0] uop_addr,
    output logic              uop_last,
    output logic              stall_front,
    output logic              busy
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [NREG-1:0]     r_mask;
    logic [NREG-1:0]     w_mask_nxt;
    logic [NREG-1:0]     w_mask_rest;
    logic [ADDR_W-1:0]   r_addr;
    logic [ADDR_W-1:0]   w_addr_nxt;
    logic                r_sm;
    logic                w_sm_nxt;
    logic                w_busy;
    logic                w_last;
    logic                w_accept;
    logic                w_stall;
    logic [RIDX_W-1:0]   w_idx;

    assign w_busy      = (r_state == S_RUN);
    // Mask with its lowest set bit removed: empty means one register left.
    assign w_mask_rest = r_mask & (r_mask - NREG'(1));
    assign w_last      = w_busy & (r_mask != '0) & (w_mask_rest == '0);
    assign w_accept    = w_busy & ds_ready;

    always_comb begin
        w_idx = '0;
        for (int i = NREG - 1; i >= 0; i--) begin
            if (r_mask[i]) begin
                w_idx = RIDX_W'(i);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_mask_nxt  = r_mask;
        w_addr_nxt  = r_addr;
        w_sm_nxt    = r_sm;
        w_stall     = 1'b0;
        if (flush) begin
            w_state_nxt = S_IDLE;
            w_mask_nxt  = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start && (reg_list != '0)) begin
                        w_mask_nxt  = reg_list;
                        w_addr_nxt  = base_addr;
                        w_sm_nxt    = is_sm;
                        w_state_nxt = S_RUN;
                        w_stall     = 1'b1;
                    end
                end
                S_RUN: begin
                    // Released in the final-accept cycle so decode advances at that edge.
                    w_stall = ~(w_accept & w_last);
                    if (w_accept) begin
                        w_mask_nxt = w_mask_rest;
                        w_addr_nxt = r_addr + ADDR_W'(1);
                        if (w_last) begin
                            w_state_nxt = S_IDLE;
                        end
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_mask  <= '0;
            r_addr  <= '0;
            r_sm    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_mask  <= w_mask_nxt;
            r_addr  <= w_addr_nxt;
            r_sm    <= w_sm_nxt;
        end
    end

    assign busy        = w_busy;
    assign uop_valid   = w_busy;
    assign uop_is_sm   = w_busy & r_sm;
    assign uop_reg     = w_busy ? w_idx : '0;
    assign uop_addr    = w_busy ? r_addr : '0;
    assign uop_last    = w_last;
    assign stall_front = w_stall & ~rst;

endmodule

// File: tb/tb_lmsm_sequencer.sv
// Table-driven LM/SM sequences checked against a queue of expected micro-ops, plus flush and async-reset sequences.
module tb_lmsm_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        is_sm;
    logic [7:0]  reg_list;
    logic [15:0] base_addr;
    logic        flush;
    logic        ds_ready;
    logic        uop_valid;
    logic        uop_is_sm;
    logic [2:0]  uop_reg;
    logic [15:0] uop_addr;
    logic        uop_last;
    logic        stall_front;
    logic        busy;

    lmsm_sequencer #(.ADDR_W(16), .NREG(8), .RIDX_W(3)) dut (
        .clk(clk), .rst(rst), .start(start), .is_sm(is_sm), .reg_list(reg_list),
        .base_addr(base_addr), .flush(flush), .ds_ready(ds_ready),
        .uop_valid(uop_valid), .uop_is_sm(uop_is_sm), .uop_reg(uop_reg),
        .uop_addr(uop_addr), .uop_last(uop_last), .stall_front(stall_front), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  rg;
        logic [15:0] addr;
        logic        last;
        logic        sm;
    } exp_t;

    typedef struct {
        logic [7:0]  rl;
        logic [15:0] base;
        logic        sm;
        logic [15:0] pat;      // ds_ready per RUN cycle
        int          cyc;      // expected RUN cycles
        logic [15:0] end_addr; // internal address afterwards
    } vec_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    int   run_cycles = 0;
    int   stall_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_model(input logic [7:0] rl, input logic [15:0] base, input logic sm);
        int cnt;
        int n;
        exp_t e;
        cnt = $countones(rl);
        n = 0;
        for (int b = 0; b < 8; b++) begin
            if (rl[b]) begin
                e.rg   = 3'(b);
                e.addr = base + 16'(n);
                e.last = (n == cnt - 1);
                e.sm   = sm;
                q.push_back(e);
                n++;
            end
        end
    endtask

    // Scoreboard: every presented micro-op must match the queue head; pop on accept.
    always @(negedge clk) begin
        if (!rst) begin
            check("valid_eq_busy", {31'b0, uop_valid}, {31'b0, busy});
            if (stall_front) stall_cnt++;
            if (uop_valid) begin
                run_cycles++;
                if (q.size() == 0) begin
                    check("unexpected_uop", {29'b0, uop_reg}, 32'hFFFF_FFFF);
                end else begin
                    check("uop_reg", {29'b0, uop_reg}, {29'b0, q[0].rg});
                    check("uop_addr", {16'b0, uop_addr}, {16'b0, q[0].addr});
                    check("uop_last", {31'b0, uop_last}, {31'b0, q[0].last});
                    check("uop_is_sm", {31'b0, uop_is_sm}, {31'b0, q[0].sm});
                    check("run_stall", {31'b0, stall_front},
                          {31'b0, (!flush && !(ds_ready && q[0].last))});
                    if (ds_ready && !flush) void'(q.pop_front());
                end
            end
        end
    end

    task automatic run_vec(input vec_t v);
        int c0;
        int s0;
        int k;
        @(posedge clk); #1;
        start = 1'b1; reg_list = v.rl; base_addr = v.base; is_sm = v.sm; ds_ready = v.pat[0];
        push_model(v.rl, v.base, v.sm);
        c0 = run_cycles;
        s0 = stall_cnt;
        @(negedge clk);
        check("idle_stall", {31'b0, stall_front}, {31'b0, (v.rl != 8'h00)});
        check("idle_valid", {31'b0, uop_valid}, 32'd0);
        k = 0;
        for (int it = 0; it < 40; it++) begin
            @(posedge clk); #1;
            if (!busy) break;
            ds_ready = v.pat[k];
            k++;
        end
        start = 1'b0;
        ds_ready = 1'b1;
        check("run_cycles", run_cycles - c0, v.cyc);
        check("stall_cycles", stall_cnt - s0, v.cyc);
        check("sb_empty", q.size(), 0);
        check("end_busy", {31'b0, busy}, 32'd0);
        check("end_addr", {16'b0, dut.r_addr}, {16'b0, v.end_addr});
    endtask

    vec_t vt[6];

    initial begin
        vt[0] = '{rl: 8'hA5, base: 16'h0040, sm: 1'b0, pat: 16'hFFFF, cyc: 4,  end_addr: 16'h0044};
        vt[1] = '{rl: 8'hA5, base: 16'h0040, sm: 1'b1, pat: 16'hFFF9, cyc: 6,  end_addr: 16'h0044};
        vt[2] = '{rl: 8'h00, base: 16'h0010, sm: 1'b0, pat: 16'hFFFF, cyc: 0,  end_addr: 16'h0044};
        vt[3] = '{rl: 8'h80, base: 16'hFFFF, sm: 1'b0, pat: 16'hFFFF, cyc: 1,  end_addr: 16'h0000};
        vt[4] = '{rl: 8'hFF, base: 16'h1234, sm: 1'b1, pat: 16'hAAAA, cyc: 16, end_addr: 16'h123C};
        vt[5] = '{rl: 8'h18, base: 16'h7FFE, sm: 1'b0, pat: 16'hFFFF, cyc: 2,  end_addr: 16'h8000};

        rst = 1'b1; start = 1'b1; is_sm = 1'b1; reg_list = 8'hFF; base_addr = 16'hBEEF;
        flush = 1'b0; ds_ready = 1'b1;
        #12;
        check("rst_stall", {31'b0, stall_front}, 32'd0);
        check("rst_valid", {31'b0, uop_valid}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        start = 1'b0;
        #5 rst = 1'b0;

        for (int i = 0; i < 6; i++) run_vec(vt[i]);

        // Flush on the second micro-op, then a clean restart.
        @(posedge clk); #1;
        start = 1'b1; reg_list = 8'hA5; base_addr = 16'h0040; is_sm = 1'b0; ds_ready = 1'b1;
        push_model(8'hA5, 16'h0040, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        flush = 1'b1;
        @(negedge clk);
        check("flush_stall", {31'b0, stall_front}, 32'd0);
        check("flush_reg", {29'b0, uop_reg}, 32'd2);
        @(posedge clk); #1;
        flush = 1'b0; start = 1'b0;
        q.delete();
        check("flush_valid", {31'b0, uop_valid}, 32'd0);
        check("flush_busy", {31'b0, busy}, 32'd0);
        check("flush_mask", {24'b0, dut.r_mask}, 32'd0);
        run_vec(vt[5]);

        // Asynchronous reset between edges while running.
        @(posedge clk); #1;
        start = 1'b1; reg_list = 8'hFF; base_addr = 16'h0100; is_sm = 1'b1; ds_ready = 1'b1;
        push_model(8'hFF, 16'h0100, 1'b1);
        @(posedge clk); #1;
        @(posedge clk); #3;
        check("pre_rst_busy", {31'b0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        check("arst_valid", {31'b0, uop_valid}, 32'd0);
        check("arst_busy", {31'b0, busy}, 32'd0);
        check("arst_stall", {31'b0, stall_front}, 32'd0);
        check("arst_addr", {16'b0, uop_addr}, 32'd0);
        check("arst_sm", {31'b0, uop_is_sm}, 32'd0);
        start = 1'b0;
        q.delete();
        #10 rst = 1'b0;
        @(negedge clk);
        check("post_rst_mask", {24'b0, dut.r_mask}, 32'd0);
        check("post_rst_busy", {31'b0, busy}, 32'd0);
        run_vec(vt[3]);

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
